// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control block: FSM state encoding and
// default width of the stall-cycle counter.
package pipeline_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        REDIRECT  = 2'd2,
        DMEM_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX targets a register read by the
// instruction in ID (x0 never creates a hazard).
module hazard_detect (
    input  logic [4:0] IFID_RS1,
    input  logic [4:0] IFID_RS2,
    input  logic [4:0] IDEX_RD,
    input  logic       IDEX_MEMREAD,
    output logic       LOAD_USE
);

    assign LOAD_USE = IDEX_MEMREAD && (IDEX_RD != '0) &&
                      ((IDEX_RD == IFID_RS1) || (IDEX_RD == IFID_RS2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: combinational HOLD/FLUSH decode from the
// current state and hazard inputs, plus stall and redirect counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       IFID_RS1,
    input  logic [4:0]       IFID_RS2,
    input  logic [4:0]       IDEX_RD,
    input  logic             IDEX_MEMREAD,
    input  logic             BRANCH_TAKEN,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    output logic             PC_HOLD,
    output logic             IFID_HOLD,
    output logic             IDEX_HOLD,
    output logic             EXMEM_HOLD,
    output logic             MEMWB_HOLD,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic [7:0]       FLUSH_COUNT
);

    state_t state;
    state_t state_nxt;
    logic   pend;
    logic   pend_nxt;
    logic   load_use;
    logic   do_branch;

    hazard_detect u_hazard (
        .IFID_RS1     (IFID_RS1),
        .IFID_RS2     (IFID_RS2),
        .IDEX_RD      (IDEX_RD),
        .IDEX_MEMREAD (IDEX_MEMREAD),
        .LOAD_USE     (load_use)
    );

    assign STATE = state;

    always_comb begin
        PC_HOLD    = 1'b0;
        IFID_HOLD  = 1'b0;
        IDEX_HOLD  = 1'b0;
        EXMEM_HOLD = 1'b0;
        MEMWB_HOLD = 1'b0;
        IFID_FLUSH = 1'b0;
        IDEX_FLUSH = 1'b0;
        state_nxt  = RUN;
        pend_nxt   = 1'b0;
        do_branch  = 1'b0;
        if (RESET) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
        end else if (DMEM_BUSY) begin
            PC_HOLD    = 1'b1;
            IFID_HOLD  = 1'b1;
            IDEX_HOLD  = 1'b1;
            EXMEM_HOLD = 1'b1;
            MEMWB_HOLD = 1'b1;
            state_nxt  = DMEM_WAIT;
            // A frozen branch is remembered; REDIRECT's EX slot is a bubble.
            pend_nxt   = pend || (BRANCH_TAKEN && (state != REDIRECT));
        end else begin
            case (state)
                REDIRECT: IFID_FLUSH = 1'b1;
                default: begin
                    if (BRANCH_TAKEN || ((state == DMEM_WAIT) && pend)) begin
                        IFID_FLUSH = 1'b1;
                        IDEX_FLUSH = 1'b1;
                        do_branch  = 1'b1;
                        state_nxt  = REDIRECT;
                    end else if (load_use && (state != LU_STALL)) begin
                        PC_HOLD    = 1'b1;
                        IFID_HOLD  = 1'b1;
                        IDEX_FLUSH = 1'b1;
                        state_nxt  = LU_STALL;
                    end else if (IMEM_BUSY) begin
                        PC_HOLD    = 1'b1;
                        IFID_FLUSH = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= RUN;
            pend         <= 1'b0;
            STALL_CYCLES <= '0;
            FLUSH_COUNT  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            if (PC_HOLD && (STALL_CYCLES != '1))
                STALL_CYCLES <= STALL_CYCLES + CNT_W'(1);
            if (do_branch && (FLUSH_COUNT != '1))
                FLUSH_COUNT <= FLUSH_COUNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a flag-based behavioural model of the controller.
module tb_pipeline_ctrl;

    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [4:0]    IFID_RS1, IFID_RS2, IDEX_RD;
    logic          IDEX_MEMREAD, BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY;
    logic          PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD;
    logic          IFID_FLUSH, IDEX_FLUSH;
    logic [1:0]    STATE;
    logic [CW-1:0] STALL_CYCLES;
    logic [7:0]    FLUSH_COUNT;
    logic [6:0]    ctl;

    int checks = 0;
    int errors = 0;

    // Model: which special cycle we are in, plus the remembered branch.
    bit m_wait, m_redir, m_lu, m_pend;
    int m_stall, m_flush;
    logic [6:0]    e_ctl;
    logic [1:0]    e_state;
    logic [CW-1:0] e_stall;
    logic [7:0]    e_flush;
    bit e_br, e_hz;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET),
        .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2), .IDEX_RD(IDEX_RD),
        .IDEX_MEMREAD(IDEX_MEMREAD), .BRANCH_TAKEN(BRANCH_TAKEN),
        .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
        .PC_HOLD(PC_HOLD), .IFID_HOLD(IFID_HOLD), .IDEX_HOLD(IDEX_HOLD),
        .EXMEM_HOLD(EXMEM_HOLD), .MEMWB_HOLD(MEMWB_HOLD),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
        .STATE(STATE), .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
    );

    assign ctl = {PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD,
                  IFID_FLUSH, IDEX_FLUSH};

    always #5 CLK = ~CLK;

    task automatic idle();
        IFID_RS1 = '0; IFID_RS2 = '0; IDEX_RD = '0;
        IDEX_MEMREAD = 1'b0; BRANCH_TAKEN = 1'b0;
        IMEM_BUSY = 1'b0; DMEM_BUSY = 1'b0;
    endtask

    // Wait to mid-cycle and form expectations from the current inputs.
    task automatic sample();
        bit hz, br;
        @(negedge CLK);
        if (RESET) begin
            m_wait = 0; m_redir = 0; m_lu = 0; m_pend = 0;
            m_stall = 0; m_flush = 0;
        end
        e_state = m_wait ? 2'd3 : m_redir ? 2'd2 : m_lu ? 2'd1 : 2'd0;
        hz = IDEX_MEMREAD && IDEX_RD != 0 &&
             (IDEX_RD == IFID_RS1 || IDEX_RD == IFID_RS2) && !m_lu && !m_redir;
        br = (BRANCH_TAKEN || (m_wait && m_pend)) && !m_redir;
        e_br = 0; e_hz = 0;
        if (RESET)          e_ctl = 7'b0000011;
        else if (DMEM_BUSY) e_ctl = 7'b1111100;
        else if (m_redir)   e_ctl = 7'b0000010;
        else if (br)        begin e_ctl = 7'b0000011; e_br = 1; end
        else if (hz)        begin e_ctl = 7'b1100001; e_hz = 1; end
        else if (IMEM_BUSY) e_ctl = 7'b1000010;
        else                e_ctl = 7'b0000000;
        e_stall = CW'(m_stall);
        e_flush = 8'(m_flush);
    endtask

    // Advance the model across the rising edge, then settle for new stimulus.
    task automatic advance();
        @(posedge CLK);
        if (!RESET) begin
            if (e_ctl[6] && m_stall < STALL_MAX) m_stall++;
            if (e_br && m_flush < 255) m_flush++;
            if (DMEM_BUSY) begin
                m_pend  = m_pend || (BRANCH_TAKEN && !m_redir);
                m_wait  = 1; m_redir = 0; m_lu = 0;
            end else begin
                m_pend  = 0; m_wait = 0;
                m_redir = e_br; m_lu = e_hz;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            DMEM_BUSY = 1'(i); BRANCH_TAKEN = 1'b1; IMEM_BUSY = 1'b1;
            sample();
            checks++;
            if (ctl !== 7'b0000011 || ctl !== e_ctl) begin
                errors++;
                $display("FAIL reset_ctl cyc%0d got %b want %b", i, ctl, e_ctl);
            end
            checks++;
            if (STATE !== 2'd0 || STALL_CYCLES !== '0 || FLUSH_COUNT !== 8'd0) begin
                errors++;
                $display("FAIL reset_regs got state %0d stall %0d flush %0d want 0 0 0",
                         STATE, STALL_CYCLES, FLUSH_COUNT);
            end
            advance();
        end
        RESET = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        idle();
        IDEX_MEMREAD = 1'b1; IDEX_RD = 5'd5; IFID_RS2 = 5'd5; IFID_RS1 = 5'd7;
        sample();
        checks++;
        if (ctl !== 7'b1100001 || ctl !== e_ctl) begin
            errors++;
            $display("FAIL lu_cyc0 got %b want %b", ctl, e_ctl);
        end
        advance();
        sample();
        checks++;
        if (ctl !== 7'b0000000 || STATE !== 2'd1 || ctl !== e_ctl || STATE !== e_state) begin
            errors++;
            $display("FAIL lu_cyc1 got %b/%0d want %b/%0d", ctl, STATE, e_ctl, e_state);
        end
        advance();
        idle();
        sample();
        checks++;
        if (STATE !== 2'd0 || STALL_CYCLES !== CW'(1) || STALL_CYCLES !== e_stall) begin
            errors++;
            $display("FAIL lu_cyc2 got state %0d stall %0d want 0 1", STATE, STALL_CYCLES);
        end
        advance();
    endtask

    task automatic test_x0_no_stall();
        idle();
        IDEX_MEMREAD = 1'b1; IDEX_RD = 5'd0; IFID_RS1 = 5'd0; IFID_RS2 = 5'd3;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (ctl !== 7'b0000000 || STATE !== 2'd0 || ctl !== e_ctl) begin
                errors++;
                $display("FAIL x0_nostall cyc%0d got %b/%0d want 0000000/0", i, ctl, STATE);
            end
            advance();
        end
        idle();
    endtask

    task automatic test_branch();
        logic [7:0] f0;
        idle();
        BRANCH_TAKEN = 1'b1;
        sample();
        f0 = e_flush;
        checks++;
        if (ctl !== 7'b0000011 || ctl !== e_ctl) begin
            errors++;
            $display("FAIL br_cyc0 got %b want %b", ctl, e_ctl);
        end
        advance();
        sample();
        checks++;
        if (ctl !== 7'b0000010 || STATE !== 2'd2 || ctl !== e_ctl) begin
            errors++;
            $display("FAIL br_redirect got %b/%0d want 0000010/2", ctl, STATE);
        end
        advance();
        idle();
        sample();
        checks++;
        if (STATE !== 2'd0 || FLUSH_COUNT !== f0 + 8'd1 || FLUSH_COUNT !== e_flush) begin
            errors++;
            $display("FAIL br_count got state %0d flush %0d want 0 %0d", STATE, FLUSH_COUNT, f0 + 8'd1);
        end
        advance();
    endtask

    task automatic test_dmem_branch();
        idle();
        for (int i = 0; i < 3; i++) begin
            DMEM_BUSY = 1'b1; BRANCH_TAKEN = (i == 1);
            sample();
            checks++;
            if (ctl !== 7'b1111100 || ctl !== e_ctl) begin
                errors++;
                $display("FAIL dmem_freeze cyc%0d got %b want 1111100", i, ctl);
            end
            advance();
        end
        idle();
        sample();
        checks++;
        if (ctl !== 7'b0000011 || STATE !== 2'd3 || ctl !== e_ctl) begin
            errors++;
            $display("FAIL dmem_release got %b/%0d want 0000011/3", ctl, STATE);
        end
        advance();
        sample();
        checks++;
        if (ctl !== 7'b0000010 || STATE !== 2'd2) begin
            errors++;
            $display("FAIL dmem_redirect got %b/%0d want 0000010/2", ctl, STATE);
        end
        advance();
    endtask

    task automatic test_dmem_loaduse();
        idle();
        IDEX_MEMREAD = 1'b1; IDEX_RD = 5'd9; IFID_RS1 = 5'd9;
        DMEM_BUSY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (ctl !== 7'b1111100 || ctl !== e_ctl) begin
                errors++;
                $display("FAIL dmem_lu_freeze cyc%0d got %b want 1111100", i, ctl);
            end
            advance();
        end
        DMEM_BUSY = 1'b0;
        sample();
        checks++;
        if (ctl !== 7'b1100001 || STATE !== 2'd3 || ctl !== e_ctl) begin
            errors++;
            $display("FAIL dmem_lu_release got %b/%0d want 1100001/3", ctl, STATE);
        end
        advance();
        idle();
        sample();
        checks++;
        if (STATE !== 2'd1 || ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL dmem_lu_bubble got %b/%0d want 0000000/1", ctl, STATE);
        end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        idle();
        DMEM_BUSY = 1'b1; BRANCH_TAKEN = 1'b1;
        sample(); advance();
        sample(); advance();
        RESET = 1'b1;
        sample();
        checks++;
        if (STATE !== 2'd0 || STALL_CYCLES !== '0 || FLUSH_COUNT !== 8'd0 || ctl !== 7'b0000011) begin
            errors++;
            $display("FAIL rst_wait got state %0d stall %0d flush %0d ctl %b want 0 0 0 0000011",
                     STATE, STALL_CYCLES, FLUSH_COUNT, ctl);
        end
        advance();
        RESET = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (ctl !== 7'b0000000 || STATE !== 2'd0 || ctl !== e_ctl) begin
                errors++;
                $display("FAIL rst_wait_after cyc%0d got %b/%0d want 0000000/0", i, ctl, STATE);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        idle();
        IMEM_BUSY = 1'b1;
        for (int i = 0; i < STALL_MAX + 4; i++) begin
            sample(); advance();
        end
        idle();
        sample();
        checks++;
        if (STALL_CYCLES !== '1 || STALL_CYCLES !== e_stall) begin
            errors++;
            $display("FAIL stall_sat got %0d want %0d", STALL_CYCLES, STALL_MAX);
        end
        advance();
        for (int i = 0; i < 260; i++) begin
            BRANCH_TAKEN = 1'b1;
            sample(); advance();
            idle();
            sample();
            checks++;
            if (FLUSH_COUNT !== e_flush) begin
                errors++;
                $display("FAIL flush_cnt iter%0d got %0d want %0d", i, FLUSH_COUNT, e_flush);
            end
            advance();
        end
        sample();
        checks++;
        if (FLUSH_COUNT !== 8'd255) begin
            errors++;
            $display("FAIL flush_sat got %0d want 255", FLUSH_COUNT);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            RESET        = ($urandom_range(99) == 0);
            DMEM_BUSY    = ($urandom_range(5) == 0);
            BRANCH_TAKEN = ($urandom_range(4) == 0);
            IMEM_BUSY    = ($urandom_range(3) == 0);
            IDEX_MEMREAD = $urandom_range(1);
            IDEX_RD      = 5'($urandom_range(3));
            IFID_RS1     = 5'($urandom_range(3));
            IFID_RS2     = 5'($urandom_range(3));
            sample();
            checks++;
            if (ctl !== e_ctl || STATE !== e_state) begin
                errors++;
                $display("FAIL rnd_ctl cyc%0d got %b/%0d want %b/%0d", i, ctl, STATE, e_ctl, e_state);
            end
            checks++;
            if (STALL_CYCLES !== e_stall || FLUSH_COUNT !== e_flush) begin
                errors++;
                $display("FAIL rnd_cnt cyc%0d got %0d/%0d want %0d/%0d",
                         i, STALL_CYCLES, FLUSH_COUNT, e_stall, e_flush);
            end
            checks++;
            if (((IFID_HOLD & IFID_FLUSH) | (IDEX_HOLD & IDEX_FLUSH)) !== 1'b0) begin
                errors++;
                $display("FAIL rnd_excl cyc%0d got hold/flush %b want no overlap", i, ctl);
            end
            advance();
        end
        RESET = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_no_stall();
        test_branch();
        test_dmem_branch();
        test_dmem_loaduse();
        test_reset_mid_wait();
        test_saturation();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock, CLK; reset is RESET, asynchronous and active-high.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall-cycle counter.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 RESET  in  1  asynchronous active-high reset.
REQ-005 IFID_RS1, IFID_RS2  in  5 each  source registers of instruction in ID.
REQ-006 IDEX_RD  in  5  destination register of instruction in EX.
REQ-007 IDEX_MEMREAD  in  1  EX instruction is a load.
REQ-008 BRANCH_TAKEN  in  1  EX resolved a taken branch/jump this cycle.
REQ-009 IMEM_BUSY, DMEM_BUSY  in  1 each  instruction/data memory busy-wait.
REQ-010 PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD  out  1 each  stage register keeps its value.
REQ-011 IFID_FLUSH, IDEX_FLUSH  out  1 each  stage register loads a bubble (all-zero instruction).
REQ-012 STATE  out  2  current FSM state (debug).
REQ-013 STALL_CYCLES  out  CNT_W  saturating count of cycles with PC_HOLD=1.
REQ-014 FLUSH_COUNT  out  8  saturating count of redirects taken.

Function
REQ-015 FSM states SHALL be RUN=0, LU_STALL=1, REDIRECT=2, DMEM_WAIT=3.
REQ-016 Load-use hazard SHALL be IDEX_MEMREAD & IDEX_RD!=0 & (IDEX_RD==IFID_RS1 | IDEX_RD==IFID_RS2).
REQ-017 Outputs SHALL be combinational from STATE and inputs; state and counters update on rising CLK.
REQ-018 Priority, highest first: DMEM_BUSY > BRANCH_TAKEN > load-use > IMEM_BUSY.
REQ-019 DMEM_BUSY=1 (any state): all five HOLD=1, both FLUSH=0; next state DMEM_WAIT.
REQ-020 DMEM_WAIT: stays while DMEM_BUSY=1; BRANCH_TAKEN seen in any DMEM_WAIT cycle SHALL set pending-branch flag.
REQ-021 DMEM_WAIT with DMEM_BUSY=0: if pending flag or BRANCH_TAKEN, act as branch (REQ-022) and clear flag; else act as RUN.
REQ-022 Branch, in RUN or LU_STALL: IFID_FLUSH=1, IDEX_FLUSH=1, all HOLD=0; next state REDIRECT; FLUSH_COUNT+1.
REQ-023 REDIRECT (one cycle only): IFID_FLUSH=1, others 0; next RUN; a new BRANCH_TAKEN here SHALL be ignored (EX holds a bubble).
REQ-024 Load-use in RUN: PC_HOLD=1, IFID_HOLD=1, IDEX_FLUSH=1; next LU_STALL.
REQ-025 LU_STALL: exactly one bubble; outputs as RUN; next RUN; hazard input SHALL NOT re-stall this cycle.
REQ-026 IMEM_BUSY only, in RUN: PC_HOLD=1, IFID_FLUSH=1; state stays RUN.
REQ-027 No condition in RUN: all outputs 0.
REQ-028 STALL_CYCLES SHALL increment each cycle PC_HOLD=1, saturating at all-ones; FLUSH_COUNT saturates at 255.
REQ-029 HOLD and FLUSH for the same register SHALL never both be 1.

Reset
REQ-030 RESET=1 SHALL immediately force STATE=RUN, pending flag=0, STALL_CYCLES=0, FLUSH_COUNT=0.
REQ-031 While RESET=1: IFID_FLUSH=1, IDEX_FLUSH=1, all HOLD=0, regardless of other inputs.
REQ-032 Reset asserted mid-stall or mid-DMEM_WAIT SHALL discard the pending branch; first cycle after release is RUN.

Structure
REQ-033 State encodings and CNT_W default SHALL live in shared package pipeline_pkg.
REQ-034 Hazard compare (REQ-016) SHALL be sub-module hazard_detect; FSM and counters stay in pipeline_ctrl.

Verification
REQ-035 IDEX_MEMREAD=1, IDEX_RD=5, IFID_RS2=5 in RUN -> cycle0 PC_HOLD=IFID_HOLD=IDEX_FLUSH=1; cycle1 state LU_STALL, all 0; cycle2 RUN; STALL_CYCLES=1.
REQ-036 Same with IDEX_RD=0=IFID_RS1 -> no stall, outputs 0.
REQ-037 BRANCH_TAKEN pulse in RUN -> cycle0 both FLUSH=1; cycle1 IFID_FLUSH only; FLUSH_COUNT=1.
REQ-038 DMEM_BUSY 3 cycles with BRANCH_TAKEN in cycle 1 -> all HOLD=1 for 3 cycles; release cycle both FLUSH=1; then REDIRECT.
REQ-039 DMEM_BUSY and load-use simultaneously -> full freeze, no IDEX_FLUSH; load-use stall follows release.
REQ-040 RESET asserted during DMEM_WAIT with pending branch -> STATE=0, counters 0, no flush burst after release.
